// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
// Shared definitions for the button conditioner: the auto-repeat FSM state
// type, the default timing constants used as parameter defaults, and a small
// helper used to size the repeat timer.
package button_conditioner_pkg;

  // Auto-repeat FSM states: waiting for a press, counting the initial delay,
  // and emitting periodic repeat pulses.
  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } repeat_state_t;

  localparam int DEFAULT_N_BTN           = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_cell.sv
// debounce_cell
// One button channel: 2-flop synchronizer on the inverted raw input, a
// mismatch counter that accepts a level change after DEBOUNCE_CYCLES stable
// cycles, registered press/release pulses and, when the macro
// BUTTON_CONDITIONER_REPEAT_EN is defined, an auto-repeat FSM.
//
// Ports:
//   clk       - clock, all state on posedge
//   reset     - synchronous active-high reset
//   w_button  - raw asynchronous button, active-low
//   level     - debounced state, 1 = pressed
//   pressed   - one-cycle pulse on accepted press (plus repeat pulses)
//   released  - one-cycle pulse on accepted release
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic w_button,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_btn;
  logic [CNT_W-1:0] count;
  logic             accept;

  // A change is accepted on the edge where the counter already holds
  // DEBOUNCE_CYCLES-1 and the input still disagrees with level, so the
  // counter tops out at DEBOUNCE_CYCLES-1 and never wraps.
  assign accept = (sync_btn != level) && (count == CNT_LAST);

  // Invert to active-high and bring the raw button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_btn  <= 1'b0;
    end else begin
      sync_meta <= ~w_button;
      sync_btn  <= sync_meta;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the
  // count, so glitches shorter than the window never reach level.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_btn == level) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
      level <= ~level;
    end else begin
      count <= count + 1'b1;
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int TMR_W = max_int($clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)), 1);

  repeat_state_t    state;
  logic [TMR_W-1:0] timer;

  // Pulse generation with auto-repeat. An accepted release always wins and
  // returns to IDLE, so a repeat that would land on the release edge is
  // suppressed. The timer restarts at every pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= 1'b0;
      released <= 1'b0;
      if (accept && level) begin
        released <= 1'b1;
        state    <= IDLE;
        timer    <= '0;
      end else if (accept) begin
        pressed <= 1'b1;
        state   <= DELAY;
        timer   <= '0;
      end else begin
        case (state)
          DELAY: begin
            if (timer == TMR_W'(REPEAT_DELAY - 1)) begin
              pressed <= 1'b1;
              state   <= REPEAT;
              timer   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPEAT: begin
            if (timer == TMR_W'(REPEAT_PERIOD - 1)) begin
              pressed <= 1'b1;
              timer   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            timer <= '0;
          end
        endcase
      end
    end
  end
`else
  // Plain edge pulses: registered alongside the level toggle so each pulse
  // lines up with the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= accept && !level;
      released <= accept && level;
    end
  end
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
// Debounces N_BTN independent active-low buttons and produces a debounced
// level plus press/release pulses per channel. Defining the macro
// BUTTON_CONDITIONER_REPEAT_EN adds per-channel auto-repeat of the press
// pulse (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD).
//
// Ports:
//   clk       - clock, all state on posedge
//   reset     - synchronous active-high reset
//   w_button  - [N_BTN] raw asynchronous buttons, active-low
//   level     - [N_BTN] debounced state, 1 = pressed
//   pressed   - [N_BTN] one-cycle press pulses (plus repeat pulses)
//   released  - [N_BTN] one-cycle release pulses
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] w_button,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] released
);

  // Every channel is a self-contained cell; nothing is shared between them.
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .w_button(w_button[i]),
      .level   (level[i]),
      .pressed (pressed[i]),
      .released(released[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Self-checking bench for button_conditioner with N_BTN=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. A behavioural model tracks each channel
// and every cycle is compared; directed scenarios add timing checks.
// Build with BUTTON_CONDITIONER_REPEAT_EN defined to cover auto-repeat.
module tb_button_conditioner;

  localparam int N_BTN = 2;
  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RPER  = 3;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] w_button;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] released;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .w_button(w_button),
    .level   (level),
    .pressed (pressed),
    .released(released)
  );

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  bit check_en = 1'b0;

  logic             s_reset;
  logic [N_BTN-1:0] s_btn;

  // Behavioural model state, one entry per channel.
  int m_sync1 [N_BTN];
  int m_sync2 [N_BTN];
  int m_streak[N_BTN];
  int m_level [N_BTN];
  int m_since [N_BTN];
  logic [N_BTN-1:0] exp_level;
  logic [N_BTN-1:0] exp_pressed;
  logic [N_BTN-1:0] exp_released;

  // Per-scenario event statistics gathered from the DUT outputs.
  int press_count  [N_BTN];
  int release_count[N_BTN];
  int first_press  [N_BTN];
  int second_press [N_BTN];
  int first_release[N_BTN];
  int level_high   [N_BTN];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h",
               tag, edge_cnt, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N_BTN-1:0] b);
    reset    = r;
    w_button = b;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    for (int i = 0; i < N_BTN; i++) begin
      press_count[i]   = 0;
      release_count[i] = 0;
      first_press[i]   = -1;
      second_press[i]  = -1;
      first_release[i] = -1;
      level_high[i]    = 0;
    end
  endtask

  // Reference behaviour for one clock edge: the input passes through two
  // sample stages; level flips once the delayed input has disagreed with it
  // on DEB consecutive edges. Press pulses at acceptance and, with repeat,
  // RDLY edges later and then every RPER edges while still held.
  task automatic modelStep();
    for (int i = 0; i < N_BTN; i++) begin
      bit accepted;
      accepted        = 1'b0;
      exp_pressed[i]  = 1'b0;
      exp_released[i] = 1'b0;
      if (s_reset) begin
        m_sync1[i]  = 0;
        m_sync2[i]  = 0;
        m_streak[i] = 0;
        m_level[i]  = 0;
        m_since[i]  = 0;
      end else begin
        if (m_sync2[i] != m_level[i]) m_streak[i]++;
        else m_streak[i] = 0;
        if (m_streak[i] == DEB) begin
          accepted    = 1'b1;
          m_streak[i] = 0;
          m_level[i]  = 1 - m_level[i];
        end
        if (accepted && m_level[i] == 1) begin
          exp_pressed[i] = 1'b1;
          m_since[i]     = 0;
        end else if (accepted) begin
          exp_released[i] = 1'b1;
        end else if (m_level[i] == 1) begin
          m_since[i]++;
          if (REPEAT_ON && m_since[i] >= RDLY && ((m_since[i] - RDLY) % RPER) == 0)
            exp_pressed[i] = 1'b1;
        end
        m_sync2[i] = m_sync1[i];
        m_sync1[i] = s_btn[i] ? 0 : 1;
      end
      exp_level[i] = (m_level[i] != 0);
    end
  endtask

  // Edge counter and input capture exactly as the DUT sees them.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    s_reset  <= reset;
    s_btn    <= w_button;
  end

  // Advance the model, compare every output, and collect statistics.
  always @(negedge clk) begin
    modelStep();
    if (check_en) begin
      checkOutput("level", 32'(level), 32'(exp_level));
      checkOutput("pressed", 32'(pressed), 32'(exp_pressed));
      checkOutput("released", 32'(released), 32'(exp_released));
      checkOutput("exclusive", 32'(pressed & released), 32'd0);
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (pressed[i] === 1'b1) begin
        press_count[i]++;
        if (first_press[i] < 0) first_press[i] = edge_cnt;
        else if (second_press[i] < 0) second_press[i] = edge_cnt;
      end
      if (released[i] === 1'b1) begin
        release_count[i]++;
        if (first_release[i] < 0) first_release[i] = edge_cnt;
      end
      if (level[i] === 1'b1) level_high[i]++;
    end
  end

  initial begin
    int base;
    int gap;
    clearStats();
    applyStimulus(1'b1, 2'b11);
    waitEdges(3);
    check_en = 1'b1;
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_pressed", 32'(pressed), 32'd0);
    checkOutput("reset_released", 32'(released), 32'd0);
    applyStimulus(1'b0, 2'b11);
    waitEdges(3);

    $display("[TB] single press on channel 0");
    base = edge_cnt;
    clearStats();
    applyStimulus(1'b0, 2'b10);
    waitEdges(9);
    applyStimulus(1'b0, 2'b11);
    waitEdges(10);
    checkOutput("press_latency", 32'(first_press[0] - base), 32'd6);
    checkOutput("press_count", 32'(press_count[0]), 32'd1);
    checkOutput("release_latency", 32'(first_release[0] - base), 32'd15);
    checkOutput("release_count", 32'(release_count[0]), 32'd1);
    checkOutput("level_high_cycles", 32'(level_high[0]), 32'd9);

    $display("[TB] three-cycle glitch on channel 0");
    clearStats();
    applyStimulus(1'b0, 2'b10);
    waitEdges(3);
    applyStimulus(1'b0, 2'b11);
    waitEdges(10);
    checkOutput("glitch_press", 32'(press_count[0]), 32'd0);
    checkOutput("glitch_release", 32'(release_count[0]), 32'd0);
    checkOutput("glitch_level", 32'(level_high[0]), 32'd0);

    $display("[TB] simultaneous press and release on both channels");
    base = edge_cnt;
    clearStats();
    applyStimulus(1'b0, 2'b00);
    waitEdges(20);
    applyStimulus(1'b0, 2'b11);
    waitEdges(10);
    checkOutput("both_press0", 32'(first_press[0] - base), 32'd6);
    checkOutput("both_press_same", 32'(first_press[1]), 32'(first_press[0]));
    checkOutput("both_release0", 32'(first_release[0] - base), 32'd26);
    checkOutput("both_release_same", 32'(first_release[1]), 32'(first_release[0]));

    $display("[TB] reset in the middle of a debounce");
    base = edge_cnt;
    clearStats();
    applyStimulus(1'b0, 2'b10);
    waitEdges(4);
    applyStimulus(1'b1, 2'b10);
    waitEdges(1);
    applyStimulus(1'b0, 2'b10);
    checkOutput("midreset_level", 32'(level), 32'd0);
    checkOutput("midreset_pressed", 32'(pressed), 32'd0);
    waitEdges(10);
    applyStimulus(1'b0, 2'b11);
    waitEdges(10);
    checkOutput("midreset_press_edge", 32'(first_press[0] - base), 32'd11);
    checkOutput("midreset_press_count", 32'(press_count[0]), 32'd1);

    $display("[TB] long hold on channel 1");
    base = edge_cnt;
    clearStats();
    applyStimulus(1'b0, 2'b01);
    waitEdges(46);
    applyStimulus(1'b0, 2'b11);
    waitEdges(12);
    checkOutput("hold_first_press", 32'(first_press[1] - base), 32'd6);
    checkOutput("hold_second_press",
                32'((second_press[1] < 0) ? -1 : second_press[1] - base),
                32'(REPEAT_ON ? 16 : -1));
    checkOutput("hold_press_count", 32'(press_count[1]), 32'(REPEAT_ON ? 13 : 1));
    checkOutput("hold_release_count", 32'(release_count[1]), 32'd1);
    checkOutput("hold_other_channel", 32'(press_count[0]), 32'd0);

    $display("[TB] randomized stimulus");
    for (int n = 0; n < 300; n++) begin
      logic [N_BTN-1:0] b;
      logic             r;
      b   = N_BTN'($urandom);
      r   = ($urandom_range(0, 39) == 0);
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
      applyStimulus(r, b);
      waitEdges(gap);
    end
    applyStimulus(1'b0, 2'b11);
    waitEdges(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter N_BTN, default 2: number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a level change; legal range 2..2^20.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 25000000: cycles from accepted press to first auto-repeat pulse.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state on posedge clk.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port w_button, input, N_BTN: raw asynchronous buttons, active-low (0 = pressed).
REQ-008 The block SHALL have port level, output, N_BTN: debounced button state, 1 = pressed.
REQ-009 The block SHALL have port pressed, output, N_BTN: one-cycle pulse per accepted press, plus auto-repeat pulses when enabled.
REQ-010 The block SHALL have port released, output, N_BTN: one-cycle pulse per accepted release.

Function
REQ-011 Each w_button bit SHALL be inverted and passed through a 2-flop synchronizer before any other use.
REQ-012 Per channel, a counter SHALL clear whenever the synchronized value equals level, and SHALL increment otherwise.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, level SHALL toggle on that edge and the counter SHALL clear.
REQ-014 Latency: a raw change held steady from edge k SHALL appear on level at edge k+2+DEBOUNCE_CYCLES.
REQ-015 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on level, pressed or released.
REQ-016 pressed[i] SHALL be high exactly in the first cycle level[i] reads 1; released[i] SHALL be high exactly in the first cycle level[i] reads 0.
REQ-017 pressed and released SHALL be registered outputs and SHALL never both be high for one channel.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap.

Reset
REQ-020 While reset is high at a clock edge, synchronizer flops, counters, level, pressed, released and repeat state SHALL all become 0 / IDLE.
REQ-021 Reset asserted mid-debounce or mid-repeat SHALL abort that activity without emitting any pulse; a button held through reset release SHALL be accepted as a new press after the full REQ-014 latency.

Configuration
REQ-022 With macro BUTTON_CONDITIONER_REPEAT_EN defined, each channel SHALL contain an auto-repeat FSM with states IDLE, DELAY, REPEAT.
REQ-023 FSM transitions: IDLE->DELAY on accepted press; DELAY->REPEAT after REPEAT_DELAY cycles with one pressed pulse; in REPEAT, one pressed pulse every REPEAT_PERIOD cycles; any state->IDLE on accepted release, no pulse in that cycle.
REQ-024 Without the macro, no repeat FSM or timer SHALL be synthesized and pressed SHALL pulse only per REQ-016; REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored.

Structure
REQ-025 Package button_conditioner_pkg SHALL hold the repeat FSM state typedef (IDLE, DELAY, REPEAT) and the default timing constants.
REQ-026 One sub-module, debounce_cell, SHALL implement a single channel (synchronizer, counter, level, pulses, optional FSM) and SHALL be instantiated N_BTN times by generate.

Verification (bench parameters: N_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 w_button[0] driven 0 from edge 10 and held -> level[0]=1 and pressed[0]=1 at edge 16 only; released stays 0.
REQ-028 w_button[0] pulsed 0 for 3 cycles, then 1 -> level, pressed and released stay 0 throughout.
REQ-029 Both buttons driven 0 at the same edge, then released together 20 cycles later -> pressed=2'b11 in one cycle, later released=2'b11 in one cycle.
REQ-030 reset asserted for 1 cycle at edge 14 during the press of REQ-027 -> all outputs 0 from edge 15; level[0]=1 with pressed pulse at edge 21.
REQ-031 Macro defined, button 1 held 40 cycles after acceptance -> pressed[1] pulses at acceptance, +10, +13, +16, ...; stops at release.
REQ-032 Macro undefined, same stimulus as REQ-031 -> exactly one pressed[1] pulse.
